// File: rtl/scanout_pkg.sv
// rtl/scanout_pkg.sv - shared types and geometry defaults for frame buffer scanout
package scanout_pkg;

    localparam logic [16:0] FB_LAST_ADDR = 17'd76799;
    localparam int          H_PIX_DEF    = 320;
    localparam int          V_PIX_DEF    = 240;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } scan_state_t;

endpackage

// File: rtl/frame_buf_scanout_if.sv
// rtl/frame_buf_scanout_if.sv - frame buffer read port and pixel stream bundle
interface frame_buf_scanout_if;
    import scanout_pkg::*;

    logic        fb_grant;
    logic        frame_buf_re;
    logic [16:0] frame_buf_addr;
    logic [23:0] frame_buf_data;
    logic        pix_valid;
    logic        pix_ready;
    pixel_t      pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;

    modport master (
        input  fb_grant, frame_buf_data, pix_ready,
        output frame_buf_re, frame_buf_addr,
        output pix_valid, pix_data, pix_sof, pix_eol, pix_eof
    );

    modport slave (
        output fb_grant, frame_buf_data, pix_ready,
        input  frame_buf_re, frame_buf_addr,
        input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof
    );

endinterface

// File: rtl/frame_buf_scanout_pix_fifo.sv
// rtl/frame_buf_scanout_pix_fifo.sv - first-word-fall-through pixel FIFO
module pix_fifo
    import scanout_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  pixel_t        push_data,
    input  logic          pop,
    output pixel_t        head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    pixel_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/frame_buf_scanout.sv
// rtl/frame_buf_scanout.sv - sequential frame buffer reader feeding a marked pixel stream
// SCANOUT_PIX_DOUBLE_EN: present every fetched pixel for two output transfers.
module frame_buf_scanout
    import scanout_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int H_PIX      = H_PIX_DEF,
    parameter int V_PIX      = V_PIX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                done,
    frame_buf_scanout_if.master bus
);

`ifdef SCANOUT_PIX_DOUBLE_EN
    localparam int REP = 2;
`else
    localparam int REP = 1;
`endif
    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int              XW        = $clog2(H_PIX * REP);
    localparam int              YW        = $clog2(V_PIX);
    localparam logic [16:0]     LAST_ADDR = 17'(H_PIX * V_PIX - 1);
    localparam logic [XW-1:0]   X_LAST    = XW'(H_PIX * REP - 1);
    localparam logic [YW-1:0]   Y_LAST    = YW'(V_PIX - 1);

    scan_state_t   state_q, state_d;
    logic [16:0]   addr_q, addr_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          inflight_q, inflight_d;
    logic          fb_re, xfer, pop, credit_ok, at_eol, at_eof;
    pixel_t        head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;

    pix_fifo #(.DEPTH(FIFO_DEPTH)) u_pix_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (pixel_t'(bus.frame_buf_data)),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A read is allowed only if its data is sure to find a free slot next cycle.
    assign credit_ok = !fifo_full && ((fifo_count + CW'(inflight_q)) < CW'(FIFO_DEPTH));
    assign at_eol    = x_q == X_LAST;
    assign at_eof    = at_eol && (y_q == Y_LAST);
    assign xfer      = bus.pix_valid && bus.pix_ready;
`ifdef SCANOUT_PIX_DOUBLE_EN
    assign pop       = xfer && x_q[0];
`else
    assign pop       = xfer;
`endif

    assign done               = state_q == IDLE;
    assign bus.frame_buf_re   = fb_re;
    assign bus.frame_buf_addr = addr_q;
    assign bus.pix_valid      = !fifo_empty;
    assign bus.pix_data       = fifo_empty ? '0 : head;
    assign bus.pix_sof        = !fifo_empty && (x_q == '0) && (y_q == '0);
    assign bus.pix_eol        = !fifo_empty && at_eol;
    assign bus.pix_eof        = !fifo_empty && at_eof;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        x_d        = x_q;
        y_d        = y_q;
        fb_re      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (bus.fb_grant && credit_ok) begin
                    fb_re = 1'b1;
                    if (addr_q == LAST_ADDR) state_d = DRAIN;
                    else                     addr_d  = addr_q + 17'd1;
                end
            end
            DRAIN: begin
                if (xfer && at_eof) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (xfer) begin
            if (at_eol) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
        inflight_d = fb_re;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_frame_buf_scanout.sv
// tb/tb_frame_buf_scanout.sv - randomized scanout bench against a frame-level pixel model
module tb_frame_buf_scanout;
    import scanout_pkg::*;

    localparam int DEPTH = 8;
    localparam int H     = 16;
    localparam int V     = 6;
    localparam int N     = H * V;
`ifdef SCANOUT_PIX_DOUBLE_EN
    localparam int REP = 2;
`else
    localparam int REP = 1;
`endif
    localparam int TOTAL = N * REP;
    localparam int LINE  = H * REP;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic        grant = 1'b0;
    logic        done;
    logic [23:0] fb_rdata = '0;
    logic [23:0] ram [N];

    int cyc = 0;
    int checks = 0;
    int fails = 0;
    int k = 0;
    int strobes = 0;
    int frames_started = 0;
    int frames_ended = 0;
    int frames_done = 0;
    int done_target = 0;
    int start_cyc = 0;
    int first_valid_cyc = -1;
    int done_cyc = 0;
    int sof_cnt = 0;
    int eol_cnt = 0;
    bit eof_seen = 0;

    frame_buf_scanout_if bus ();
    assign bus.fb_grant       = grant;
    assign bus.pix_ready      = ready;
    assign bus.frame_buf_data = fb_rdata;

    frame_buf_scanout #(.FIFO_DEPTH(DEPTH), .H_PIX(H), .V_PIX(V)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.frame_buf_re) fb_rdata <= ram[int'(bus.frame_buf_addr)];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: transfer k of a frame carries source pixel k/REP at output column k%LINE.
    always @(negedge clk) begin
        if (!rst) begin
            k = 0;
            strobes = 0;
            eof_seen = 0;
            frames_ended = frames_started;
        end else begin
            if (eof_seen) begin
                chk("done_after_eof", done, 1);
                eof_seen = 0;
                done_cyc = cyc;
                frames_done++;
            end
            if (bus.frame_buf_re) begin
                chk("strobe_addr", bus.frame_buf_addr, strobes);
                chk("strobe_granted", grant, 1);
                chk("strobe_fifo_space", (strobes - k / REP) < DEPTH, 1);
                strobes++;
            end
            if (bus.pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.pix_valid && ready) begin
                chk("xfer_expected", frames_ended < frames_started, 1);
                chk("busy_during_xfer", done, 0);
                chk("pix_data", bus.pix_data, ram[k / REP]);
                chk("pix_sof", bus.pix_sof, k == 0);
                chk("pix_eol", bus.pix_eol, (k % LINE) == LINE - 1);
                chk("pix_eof", bus.pix_eof, k == TOTAL - 1);
                sof_cnt += int'(bus.pix_sof);
                eol_cnt += int'(bus.pix_eol);
                k++;
                if (k == TOTAL) begin
                    eof_seen = 1;
                    k = 0;
                    strobes = 0;
                    frames_ended++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        for (int i = 0; i < N; i++) ram[i] = 24'($urandom);
        start = 1'b1;
        start_cyc = cyc;
        first_valid_cyc = -1;
        sof_cnt = 0;
        eol_cnt = 0;
        frames_started++;
        done_target++;
        tick();
        start = 1'b0;
        chk("busy_after_start", done, 0);
        if (grant) begin
            chk("first_strobe", bus.frame_buf_re, 1);
            chk("first_addr", bus.frame_buf_addr, 0);
        end
    endtask

    task automatic wait_frame(input int budget);
        int n = 0;
        while (frames_done < done_target && n < budget) begin
            tick();
            n++;
        end
        chk("frame_completes", frames_done, done_target);
    endtask

    initial begin
        int n;
        int hold;
        grant = 1'b1;
        ready = 1'b1;
        repeat (3) tick();
        chk("rst_done", done, 1);
        chk("rst_re", bus.frame_buf_re, 0);
        chk("rst_addr", bus.frame_buf_addr, 0);
        chk("rst_valid", bus.pix_valid, 0);
        chk("rst_markers", {bus.pix_sof, bus.pix_eol, bus.pix_eof}, 0);
        chk("rst_data", bus.pix_data, 0);
        rst = 1'b1;
        tick();

        // Full-rate frame: latency and frame time pinned by hand.
        begin_frame();
        wait_frame(TOTAL + 50);
        chk("first_pixel_latency", first_valid_cyc - start_cyc, 3);
        chk("frame_cycles", done_cyc - start_cyc, TOTAL + 3);
        chk("sof_count", sof_cnt, 1);
        chk("eol_count", eol_cnt, 6);
        tick();

        // Sink stalls after the 5th pixel: FIFO fills, reads stop, stream holds.
        begin_frame();
        n = 0;
        while (k < 5 && n < 100) begin tick(); n++; end
        ready = 1'b0;
        repeat (50) tick();
        chk("stall_valid", bus.pix_valid, 1);
        chk("stall_no_strobe", bus.frame_buf_re, 0);
        chk("stall_buffered_max", (strobes - k / REP) <= DEPTH, 1);
        chk("stall_buffered", strobes - k / REP, DEPTH);
        ready = 1'b1;
        wait_frame(TOTAL + 100);

        // Grant withdrawn mid-frame: address holds, no strobes.
        begin_frame();
        n = 0;
        while (strobes < 50 && n < 400) begin tick(); n++; end
        grant = 1'b0;
        hold = int'(bus.frame_buf_addr);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0 || i == 19) begin
                chk("nogrant_addr_hold", bus.frame_buf_addr, hold);
                chk("nogrant_no_strobe", bus.frame_buf_re, 0);
            end
        end
        grant = 1'b1;
        wait_frame(TOTAL + 100);

        // Reset mid-frame, then a clean frame.
        begin_frame();
        n = 0;
        while (k < 40 && n < 400) begin tick(); n++; end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        done_target--;
        chk("abort_done", done, 1);
        chk("abort_valid", bus.pix_valid, 0);
        chk("abort_addr", bus.frame_buf_addr, 0);
        tick();
        begin_frame();
        wait_frame(TOTAL + 50);

        // start during FETCH must not spawn another frame.
        begin_frame();
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_frame(TOTAL + 50);
        repeat (20) tick();
        chk("idle_after_frame", done, 1);
        chk("idle_no_valid", bus.pix_valid, 0);

        // Random grant/ready traffic across two frames.
        for (int f = 0; f < 2; f++) begin
            begin_frame();
            n = 0;
            while (frames_done < done_target && n < 20 * TOTAL) begin
                ready = $urandom_range(0, 3) != 0;
                grant = $urandom_range(0, 3) != 0;
                tick();
                n++;
            end
            ready = 1'b1;
            grant = 1'b1;
            wait_frame(TOTAL + 50);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/frame_buf_scanout.md
# frame_buf_scanout

Reads the 320x240, 24-bit frame buffer sequentially and streams the pixels to the display side over a valid/ready interface, with start-of-frame, end-of-line and end-of-frame markers. It sits on the read port of the frame buffer, across from the map drawer that writes it. A small internal FIFO absorbs back-pressure from the display path. A grant input keeps scanout reads off the buffer while the writer owns it.

## Interface
- FIFO_DEPTH, 8: pixel FIFO entries; power of two, at least 4.
- H_PIX, 320: source pixels per line.
- V_PIX, 240: lines per frame.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  begins one frame scan; sampled only in IDLE.
- done  output  1  high in IDLE.
- fb_grant  input  1  read port may be used this cycle.
- frame_buf_re  output  1  read strobe.
- frame_buf_addr  output  17  read address, range 0..76799.
- frame_buf_data  input  24  read data, valid exactly one cycle after the strobe.
- pix_valid  output  1  pix_data is valid.
- pix_ready  input  1  sink accepts the pixel; a transfer occurs when pix_valid && pix_ready.
- pix_data  output  24  RGB 8:8:8.
- pix_sof  output  1  first pixel of the frame (x=0, y=0).
- pix_eol  output  1  last pixel of a line.
- pix_eof  output  1  last pixel of the frame.

## Operation
- States:
  - IDLE: done=1, waits for start.
  - FETCH: issues reads.
  - DRAIN: all addresses issued; waits for the last transfer.
- Transitions:
  - IDLE to FETCH on start.
  - FETCH to DRAIN after the strobe for address H_PIX*V_PIX-1.
  - DRAIN to IDLE on the pix_eof transfer.
- Read issue (FETCH):
  - frame_buf_re=1 when fb_grant=1 and fifo_count + inflight < FIFO_DEPTH. inflight is 0 or 1.
  - The address increments after each strobe.
  - The address returns to 0 on entering IDLE.
- Capture: the cycle after a strobe, frame_buf_data is written into the FIFO unconditionally. Credit accounting guarantees space.
- Output counters:
  - x advances on each transfer and wraps at H_PIX-1; y increments on that wrap.
  - Markers are decoded from x and y of the FIFO head entry.
- Boundary behaviour:
  - fb_grant low mid-frame: no new strobes; an in-flight read is still captured; the address holds.
  - FIFO full: no strobes; pix_valid stays high.
  - FIFO empty in FETCH or DRAIN: pix_valid=0; markers are don't-care.
  - start outside IDLE: ignored.
  - Simultaneous capture and transfer: count unchanged, both occur.
  - Reset mid-frame: aborts the frame, flushes the FIFO, returns to IDLE.
- Reset values:
  - done=1
  - frame_buf_re=0
  - frame_buf_addr=0
  - pix_valid=0
  - pix_sof=0, pix_eol=0, pix_eof=0
  - pix_data=0
  - FIFO empty; x=y=0

## Timing
- start high in cycle 0 (IDLE): FETCH in cycle 1, first strobe to address 0 in cycle 1 if granted.
- Data is captured at the end of cycle 2; pix_valid rises in cycle 3.
- Start to first pixel latency is 3 cycles.
- Sustained throughput is 1 pixel/cycle with pix_ready and fb_grant held high.
- done rises the cycle after the pix_eof transfer.
- Minimum frame time is 76800 + 3 cycles.

## Configuration
- SCANOUT_PIX_DOUBLE_EN defined:
  - Each FIFO entry is presented for two consecutive transfers, and the FIFO pops on the second.
  - x spans 0..2*H_PIX-1, so pix_eol is asserted on output pixel 639.
  - Reads and lines are unchanged.
- Undefined: one transfer per entry; x spans 0..H_PIX-1.

## Structure
- scanout_pkg:
  - FB_LAST_ADDR = 17'd76799
  - H_PIX_DEF and V_PIX_DEF
  - pixel_t, a 24-bit RGB struct
  - scan_state_t: IDLE, FETCH, DRAIN
- One sub-module, pix_fifo:
  - Synchronous FIFO of pixel_t with first-word-fall-through.
  - Provides count, full and empty, and is reset by rst.
- The top level holds the FSM, address, credit logic and x/y counters.

## Test plan
- Reset, start, pix_ready=1, fb_grant=1 → 76800 transfers in 76803 cycles.
  - pix_sof only on the first; pix_eol every 320th; pix_eof on #76799.
  - done returns to 1 the cycle after.
  - pix_data equals the model RAM content at each address.
- pix_ready low for 50 cycles after the 5th pixel → at most 8 pixels buffered; frame_buf_re is 0 while full; no pixel lost or duplicated.
- fb_grant low for 20 cycles at address 1000 → no strobes; the in-flight read is captured; the stream resumes at address 1000/1001 in order.
- rst low at pixel 40000 → next cycle done=1, pix_valid=0, addr=0; a new start yields a full, correct frame.
- start pulsed during FETCH → ignored; exactly one frame produced.
- With SCANOUT_PIX_DOUBLE_EN → 153600 transfers; each value appears twice; pix_eol on x=639.
